hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 134 +++++++++++++
 tb/tb_hazard_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use/branch interlocks, data-memory wait freeze with timeout.
// Optional stall-cycle performance counter enabled by defining HAZARD_PERF_EN.
module hazard_unit #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned MEM_TMO = 255,
    parameter int unsigned TMO_W   = 8,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] if_id_rs1,
    input  logic [REG_AW-1:0] if_id_rs2,
    input  logic              if_id_use_rs1,
    input  logic              if_id_use_rs2,
    input  logic              if_id_branch,
    input  logic              br_taken,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic              id_ex_regwrite,
    input  logic              id_ex_memread,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic              ex_mem_memread,
    input  logic              ex_mem_memwrite,
    input  logic              mem_ready,
    output logic              stall_if,
    output logic              stall_id,
    output logic              bubble_ex,
    output logic              freeze,
    output logic              flush_id,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t           state;
    logic [TMO_W-1:0] tmo_cnt;
    logic             m_ex;
    logic             m_mem;
    logic             hazard;
    logic             mem_op;
    logic             tmo_hit;
    logic             freeze_c;
    logic             mem_err_c;
    logic             stall_c;

    // Source-operand matches against in-flight destinations; x0 never matches.
    always_comb begin
        m_ex  = (id_ex_rd != '0) &
                (((if_id_rs1 == id_ex_rd) & if_id_use_rs1) |
                 ((if_id_rs2 == id_ex_rd) & if_id_use_rs2));
        m_mem = (ex_mem_rd != '0) &
                (((if_id_rs1 == ex_mem_rd) & if_id_use_rs1) |
                 ((if_id_rs2 == ex_mem_rd) & if_id_use_rs2));
        hazard = (m_ex & id_ex_memread) |
                 (if_id_branch & ((m_ex & id_ex_regwrite) | (m_mem & ex_mem_memread)));
    end

    // Freeze/timeout decode from FSM state and the live memory handshake.
    always_comb begin
        freeze_c  = 1'b0;
        mem_err_c = 1'b0;
        mem_op    = ex_mem_memread | ex_mem_memwrite;
        tmo_hit   = (tmo_cnt == TMO_W'(MEM_TMO));
        case (state)
            RUN: begin
                freeze_c = mem_op & ~mem_ready;
            end
            MEM_WAIT: begin
                freeze_c  = ~mem_ready & ~tmo_hit;
                mem_err_c = ~mem_ready & tmo_hit;
            end
            default: begin
                freeze_c  = 1'b0;
                mem_err_c = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= RUN;
            tmo_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_op && !mem_ready) begin
                        state   <= MEM_WAIT;
                        tmo_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready || tmo_hit) begin
                        state <= RUN;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                default: begin
                    state   <= RUN;
                    tmo_cnt <= '0;
                end
            endcase
        end
    end

    // Freeze dominates: stages hold, no bubble, no flush; everything low in reset.
    always_comb begin
        stall_c   = freeze_c | hazard;
        stall_if  = rst_n & stall_c;
        stall_id  = rst_n & stall_c;
        bubble_ex = rst_n & ~freeze_c & hazard;
        freeze    = rst_n & freeze_c;
        flush_id  = rst_n & br_taken & ~stall_c;
        mem_err   = rst_n & mem_err_c;
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating count of cycles with the front end held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (stall_c && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = rst_n ? cnt_q : '0;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (MEM_TMO=4, CNT_W=3).
module tb_hazard_unit;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [REG_AW-1:0] if_id_rs1, if_id_rs2, id_ex_rd, ex_mem_rd;
    logic              if_id_use_rs1, if_id_use_rs2, if_id_branch, br_taken;
    logic              id_ex_regwrite, id_ex_memread;
    logic              ex_mem_memread, ex_mem_memwrite, mem_ready;
    logic              stall_if, stall_id, bubble_ex, freeze, flush_id, mem_err;
    logic [CNT_W-1:0]  stall_cnt;
    logic [5:0]        outs;

    int checks   = 0;
    int failures = 0;

    hazard_unit #(.REG_AW(REG_AW), .MEM_TMO(4), .TMO_W(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2),
        .if_id_branch(if_id_branch), .br_taken(br_taken),
        .id_ex_rd(id_ex_rd), .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread),
        .ex_mem_rd(ex_mem_rd), .ex_mem_memread(ex_mem_memread), .ex_mem_memwrite(ex_mem_memwrite),
        .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
        .freeze(freeze), .flush_id(flush_id), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // {stall_if, stall_id, bubble_ex, freeze, flush_id, mem_err}
    assign outs = {stall_if, stall_id, bubble_ex, freeze, flush_id, mem_err};

    task automatic idle();
        if_id_rs1 = '0; if_id_rs2 = '0; if_id_use_rs1 = 0; if_id_use_rs2 = 0;
        if_id_branch = 0; br_taken = 0; id_ex_rd = '0; id_ex_regwrite = 0;
        id_ex_memread = 0; ex_mem_rd = '0; ex_mem_memread = 0; ex_mem_memwrite = 0;
        mem_ready = 1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 0; idle(); step(); rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        id_ex_memread = 1; id_ex_rd = 5; if_id_rs2 = 5; if_id_use_rs2 = 1;
        ex_mem_memread = 1; mem_ready = 0; br_taken = 1;
        #1;
        checks++; if (outs !== 6'b000000) begin failures++; $display("FAIL reset_outs got=%b exp=000000", outs); end
        checks++; if (stall_cnt !== 3'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
        step();
        checks++; if (outs !== 6'b000000) begin failures++; $display("FAIL reset_held got=%b exp=000000", outs); end
        idle(); rst_n = 1; #1;
        checks++; if (outs !== 6'b000000) begin failures++; $display("FAIL reset_idle got=%b exp=000000", outs); end
        step();
    endtask

    task automatic test_load_use();
        idle(); id_ex_memread = 1; id_ex_rd = 5; if_id_rs2 = 5; if_id_use_rs2 = 1; #1;
        checks++; if (outs !== 6'b111000) begin failures++; $display("FAIL lu_rs2 got=%b exp=111000", outs); end
        if_id_use_rs2 = 0; #1;
        checks++; if (outs !== 6'b000000) begin failures++; $display("FAIL lu_nouse got=%b exp=000000", outs); end
        if_id_rs1 = 5; if_id_use_rs1 = 1; br_taken = 1; #1;
        checks++; if (outs !== 6'b111000) begin failures++; $display("FAIL lu_rs1_br got=%b exp=111000", outs); end
        id_ex_memread = 0; id_ex_regwrite = 1; #1;
        checks++; if (outs !== 6'b000010) begin failures++; $display("FAIL lu_alu_flush got=%b exp=000010", outs); end
        step();
    endtask

    task automatic test_x0();
        idle(); id_ex_memread = 1; id_ex_rd = 0; if_id_rs1 = 0; if_id_use_rs1 = 1; #1;
        checks++; if (outs !== 6'b000000) begin failures++; $display("FAIL x0_ex got=%b exp=000000", outs); end
        if_id_branch = 1; ex_mem_rd = 0; ex_mem_memread = 1; #1;
        checks++; if (outs !== 6'b000000) begin failures++; $display("FAIL x0_mem got=%b exp=000000", outs); end
        step();
    endtask

    task automatic test_branch();
        idle(); if_id_branch = 1; if_id_rs1 = 7; if_id_use_rs1 = 1; ex_mem_rd = 7; ex_mem_memread = 1; #1;
        checks++; if (outs !== 6'b111000) begin failures++; $display("FAIL br_mem got=%b exp=111000", outs); end
        if_id_branch = 0; #1;
        checks++; if (outs !== 6'b000000) begin failures++; $display("FAIL br_nobranch got=%b exp=000000", outs); end
        if_id_branch = 1; ex_mem_memread = 0; #1;
        checks++; if (outs !== 6'b000000) begin failures++; $display("FAIL br_mem_alu got=%b exp=000000", outs); end
        idle(); if_id_branch = 1; if_id_rs2 = 9; if_id_use_rs2 = 1; id_ex_rd = 9; id_ex_regwrite = 1; #1;
        checks++; if (outs !== 6'b111000) begin failures++; $display("FAIL br_ex got=%b exp=111000", outs); end
        id_ex_regwrite = 0; #1;
        checks++; if (outs !== 6'b000000) begin failures++; $display("FAIL br_ex_nowr got=%b exp=000000", outs); end
        step();
    endtask

    task automatic test_mem_wait();
        idle(); ex_mem_memread = 1; mem_ready = 0;
        id_ex_memread = 1; id_ex_rd = 3; if_id_rs1 = 3; if_id_use_rs1 = 1; br_taken = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (outs !== 6'b110100) begin failures++; $display("FAIL wait_cyc%0d got=%b exp=110100", i, outs); end
            step();
        end
        mem_ready = 1; #1;
        checks++; if (outs !== 6'b111000) begin failures++; $display("FAIL wait_done got=%b exp=111000", outs); end
        step();
        idle(); mem_ready = 0; #1;
        checks++; if (outs !== 6'b000000) begin failures++; $display("FAIL wait_after got=%b exp=000000", outs); end
        step();
    endtask

    task automatic test_timeout();
        idle(); ex_mem_memwrite = 1; mem_ready = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (outs !== 6'b110100) begin failures++; $display("FAIL tmo_cyc%0d got=%b exp=110100", i, outs); end
            step();
        end
        #1;
        checks++; if (outs !== 6'b000001) begin failures++; $display("FAIL tmo_err got=%b exp=000001", outs); end
        step();
        ex_mem_memwrite = 0; #1;
        checks++; if (outs !== 6'b000000) begin failures++; $display("FAIL tmo_after got=%b exp=000000", outs); end
        step();
    endtask

    task automatic test_tmo_ready_race();
        idle(); ex_mem_memread = 1; mem_ready = 0;
        for (int i = 0; i < 5; i++) step();
        mem_ready = 1; #1;
        checks++; if (outs !== 6'b000000) begin failures++; $display("FAIL race got=%b exp=000000", outs); end
        step();
        idle(); mem_ready = 0; #1;
        checks++; if (outs !== 6'b000000) begin failures++; $display("FAIL race_after got=%b exp=000000", outs); end
        step();
    endtask

    task automatic test_reset_mid_wait();
        idle(); ex_mem_memread = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) step();
        rst_n = 0; #1;
        checks++; if (outs !== 6'b000000) begin failures++; $display("FAIL rstwait_now got=%b exp=000000", outs); end
        step();
        rst_n = 1; ex_mem_memread = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if (outs !== 6'b000000) begin failures++; $display("FAIL rstwait_cyc%0d got=%b exp=000000", i, outs); end
            step();
        end
    endtask

    task automatic test_perf();
        logic [CNT_W-1:0] exp_cnt;
        do_reset();
        id_ex_memread = 1; id_ex_rd = 4; if_id_rs2 = 4; if_id_use_rs2 = 1; br_taken = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
`ifdef HAZARD_PERF_EN
            exp_cnt = (i > 7) ? CNT_W'(7) : CNT_W'(i);
`else
            exp_cnt = '0;
`endif
            checks++; if (outs !== 6'b111000) begin failures++; $display("FAIL perf_outs%0d got=%b exp=111000", i, outs); end
            checks++; if (stall_cnt !== exp_cnt) begin failures++; $display("FAIL perf_cnt%0d got=%0d exp=%0d", i, stall_cnt, exp_cnt); end
            step();
        end
        idle(); #1;
`ifdef HAZARD_PERF_EN
        exp_cnt = CNT_W'(7);
`else
        exp_cnt = '0;
`endif
        checks++; if (stall_cnt !== exp_cnt) begin failures++; $display("FAIL perf_final got=%0d exp=%0d", stall_cnt, exp_cnt); end
        step();
        #1;
        checks++; if (stall_cnt !== exp_cnt) begin failures++; $display("FAIL perf_hold got=%0d exp=%0d", stall_cnt, exp_cnt); end
        step();
    endtask

    initial begin
        idle();
        rst_n = 0;
        step();
        test_reset();
        test_load_use();
        test_x0();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_tmo_ready_race();
        test_reset_mid_wait();
        test_perf();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
